ac_cmd_arbiter: RTL and testbench
=================================

AC_CMD_ARBITER -- requirements
Module: ac_cmd_arbiter

Interface
REQ-001 The module SHALL have parameter NREQ, default 3: number of remote-control requesters.
REQ-002 The module SHALL have parameter NBITS_TEMP, default 3: width of the setpoint temperature.
REQ-003 The module SHALL have parameter HOLD_CYCLES, default 2: idle spacing in cycles after each issued command.
REQ-004 The module SHALL have parameter NBITS_BLK, default 4: width of the blocked-request counter.
REQ-005 The module SHALL have the port clk_2, input, 1 bit: clock, rising edge.
REQ-006 The module SHALL have the port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have the port req_up, input, NREQ bits: per-requester level request to raise the setpoint.
REQ-008 The module SHALL have the port req_dn, input, NREQ bits: per-requester level request to lower the setpoint.
REQ-009 The module SHALL have the port pingando, input, 1 bit: the AC unit is dripping, so commands are locked out.
REQ-010 The module SHALL have the port temp_desejada, input, NBITS_TEMP bits: the AC's current setpoint.
REQ-011 The module SHALL have the port aumentar, output, 1 bit: one-cycle raise command to the AC.
REQ-012 The module SHALL have the port diminuir, output, 1 bit: one-cycle lower command to the AC.
REQ-013 The module SHALL have the port grant, output, NREQ bits: one-hot winner, valid only while a command is issued.
REQ-014 The module SHALL have the port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 The module SHALL have the port blk_cnt, output, NBITS_BLK bits: saturating count of cycles in which requests were refused during lockout.

Function
REQ-016 Requester i SHALL be valid when exactly one of req_up[i] and req_dn[i] is high; a requester with both high or both low SHALL be ignored.
REQ-017 A valid raise request SHALL be ignored when temp_desejada = 2^NBITS_TEMP-1, and a valid lower request SHALL be ignored when temp_desejada = 0; such a request SHALL be neither granted nor counted.
REQ-018 The FSM SHALL have the states IDLE, ISSUE, HOLD and LOCK.
REQ-019 In IDLE with pingando=1, the FSM SHALL go to LOCK; no grant SHALL be made that cycle.
REQ-020 In IDLE with pingando=0 and at least one eligible request, the FSM SHALL select a winner and go to ISSUE on the next edge.
REQ-021 In ISSUE, the module SHALL assert grant[winner] together with exactly one of aumentar/diminuir (according to the winner's request latched in IDLE) for exactly one cycle, and SHALL then go to HOLD.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES cycles, after which the FSM SHALL go to LOCK if pingando=1 and to IDLE otherwise.
REQ-023 LOCK SHALL persist while pingando=1 and SHALL go to IDLE on the first cycle pingando=0.
REQ-024 A pingando rise during ISSUE or HOLD SHALL NOT abort the sequence in progress.
REQ-025 Latency SHALL be 1 cycle from request sampled in IDLE to the command pulse; back-to-back commands SHALL be spaced HOLD_CYCLES+2 cycles apart, pulse to pulse.
REQ-026 Arbitration SHALL be round-robin: the search SHALL start at the index following the last winner, wrapping from NREQ-1 to 0.
REQ-027 The round-robin pointer SHALL update only in ISSUE.
REQ-028 blk_cnt SHALL increment by 1 in each LOCK cycle that has any eligible request, and SHALL saturate at 2^NBITS_BLK-1 without wrapping.
REQ-029 Outside ISSUE, the outputs aumentar, diminuir and grant SHALL all be 0.

Reset
REQ-030 While reset=1 at a clk_2 edge, the module SHALL set state=IDLE, aumentar=0, diminuir=0, grant=0, busy=0 and blk_cnt=0, clear the HOLD counter, and set the round-robin pointer so that requester 0 is searched first.
REQ-031 A reset asserted mid-ISSUE/HOLD/LOCK SHALL abandon the sequence with no further pulse.

Configuration
REQ-032 With AC_ARB_MASTER_EN defined, requester 0 SHALL win whenever it is eligible, regardless of the pointer, and the remaining requesters SHALL be served round-robin; without the macro, all requesters SHALL be served pure round-robin per REQ-026.

Verification
REQ-033 After reset, req_up=3'b111 held with temp_desejada=3 -> the bench SHALL see aumentar pulses with grant=001, 010, 100, 001, spaced 4 cycles apart.
REQ-034 With req_dn[1]=1 and temp_desejada=0 -> the bench SHALL see no pulse, busy=0 and blk_cnt=0.
REQ-035 With req_up[2]=req_dn[2]=1 and the others at 0 -> the bench SHALL see no grant.
REQ-036 With pingando=1 for 20 cycles and req_up[0]=1 -> the bench SHALL see the FSM in LOCK, blk_cnt=15 (saturated), then an aumentar pulse 2 cycles after pingando falls.
REQ-037 Reset pulsed on the ISSUE cycle -> the bench SHALL see grant=0 on the following cycle and the next winner equal to requester 0.
REQ-038 With AC_ARB_MASTER_EN defined and req_up=3'b111 -> the bench SHALL see grant=001 on every pulse.

Source files
------------

// File: rtl/ac_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ac_cmd_arbiter
//
// Purpose:
//   Arbitrates raise/lower setpoint requests from NREQ remote controls and
//   issues one-cycle aumentar/diminuir commands to the AC unit. Winners are
//   picked round-robin. Each command is followed by HOLD_CYCLES idle cycles.
//   While the unit is dripping (pingando) commands are locked out, and the
//   cycles in which eligible requests were refused are counted (saturating).
//
// Optional feature (macro AC_ARB_MASTER_EN):
//   When defined, requester 0 is a master: it wins whenever it is eligible,
//   regardless of the round-robin pointer. The other requesters are served
//   round-robin. When undefined, all requesters are served pure round-robin.
//
// Parameters:
//   NREQ        - number of requesters
//   NBITS_TEMP  - width of the setpoint temperature
//   HOLD_CYCLES - idle cycles after each issued command (must be >= 1)
//   NBITS_BLK   - width of the blocked-request counter
//
// Ports:
//   clk_2         in   clock, rising edge
//   reset         in   synchronous, active-high reset
//   req_up        in   [NREQ] level request to raise the setpoint
//   req_dn        in   [NREQ] level request to lower the setpoint
//   pingando      in   AC dripping; commands are locked out
//   temp_desejada in   [NBITS_TEMP] current AC setpoint
//   aumentar      out  one-cycle raise command
//   diminuir      out  one-cycle lower command
//   grant         out  [NREQ] one-hot winner, valid only with a command
//   busy          out  high whenever the FSM is not in IDLE
//   blk_cnt       out  [NBITS_BLK] saturating count of refused-request cycles
// ---------------------------------------------------------------------------
module ac_cmd_arbiter #(
  parameter int NREQ        = 3,
  parameter int NBITS_TEMP  = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int NBITS_BLK   = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_up,
  input  logic [NREQ-1:0]       req_dn,
  input  logic                  pingando,
  input  logic [NBITS_TEMP-1:0] temp_desejada,
  output logic                  aumentar,
  output logic                  diminuir,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [NBITS_BLK-1:0]  blk_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;    // first index searched on the next arbitration
  logic [PW-1:0]   r_win;       // winner of the command currently in ISSUE
  logic [HW-1:0]   r_hold_cnt;

  logic            w_temp_max;
  logic            w_temp_min;
  logic [NREQ-1:0] w_valid;
  logic [NREQ-1:0] w_elig;
  logic            w_any_elig;
  logic [NREQ-1:0] w_rr_elig;
  logic [NREQ-1:0] w_rot;
  logic            w_rot_hit;
  logic [PW-1:0]   w_rot_off;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_rr_idx;
  logic [PW-1:0]   w_win_idx;
  logic [NREQ-1:0] w_win_onehot;
  logic            w_win_up;
  logic            w_win_dn;
  logic            w_hold_last;

  // -------------------------------------------------------------------------
  // Eligibility: exactly one direction requested, and that direction must
  // not push the setpoint past its range.
  // -------------------------------------------------------------------------
  assign w_temp_max = (temp_desejada == {NBITS_TEMP{1'b1}});
  assign w_temp_min = (temp_desejada == {NBITS_TEMP{1'b0}});

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
      assign w_valid[gi] = req_up[gi] ^ req_dn[gi];
      assign w_elig[gi]  = w_valid[gi] &
                           ((req_up[gi] & ~w_temp_max) |
                            (req_dn[gi] & ~w_temp_min));
    end
  endgenerate

  assign w_any_elig = |w_elig;

  // -------------------------------------------------------------------------
  // Round-robin search. The eligible vector is rotated so that the pointer
  // position lands on bit 0; the lowest set bit of the rotated vector is the
  // offset of the winner from the pointer.
  // -------------------------------------------------------------------------
`ifdef AC_ARB_MASTER_EN
  // Requester 0 is handled by a fixed-priority override, so the rotating
  // search only ever considers the others.
  assign w_rr_elig = w_elig & ~NREQ'(1);
`else
  assign w_rr_elig = w_elig;
`endif

  assign w_rot = NREQ'({w_rr_elig, w_rr_elig} >> r_rr_ptr);

  always_comb begin
    w_rot_hit = 1'b0;
    w_rot_off = '0;
    // Descending scan so the lowest set bit is the last one assigned.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_rot_hit = 1'b1;
        w_rot_off = PW'(k);
      end
    end
  end

  // Undo the rotation: (pointer + offset) mod NREQ.
  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
  assign w_rr_idx = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ))
                                              : PW'(w_sum);

`ifdef AC_ARB_MASTER_EN
  assign w_win_idx = w_elig[0] ? '0 : w_rr_idx;
`else
  assign w_win_idx = w_rr_idx;
`endif

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      // Qualified with a hit so a stale index never produces a grant bit.
      assign w_win_onehot[gi] = (w_win_idx == PW'(gi)) &
                                (w_rot_hit | w_elig[0]);
    end
  endgenerate

  // Direction of the winner, taken from the request as seen in IDLE.
  assign w_win_up = |(req_up & w_win_onehot);
  assign w_win_dn = |(req_dn & w_win_onehot);

  assign w_hold_last = (r_hold_cnt == HW'(HOLD_CYCLES - 1));

  // -------------------------------------------------------------------------
  // FSM with registered outputs. Command outputs default to zero every
  // cycle and are only set on the IDLE->ISSUE edge, so they are high for
  // exactly the single ISSUE cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_win      <= '0;
      r_hold_cnt <= '0;
      aumentar   <= 1'b0;
      diminuir   <= 1'b0;
      grant      <= '0;
      busy       <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      aumentar <= 1'b0;
      diminuir <= 1'b0;
      grant    <= '0;

      case (r_state)
        IDLE: begin
          if (pingando) begin
            r_state <= LOCK;
            busy    <= 1'b1;
          end else if (w_any_elig) begin
            r_state  <= ISSUE;
            busy     <= 1'b1;
            r_win    <= w_win_idx;
            grant    <= w_win_onehot;
            aumentar <= w_win_up;
            diminuir <= w_win_dn;
          end
        end

        ISSUE: begin
          // Pointer moves only here, to the requester after the winner.
          r_rr_ptr   <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
          r_hold_cnt <= '0;
          r_state    <= HOLD;
        end

        HOLD: begin
          if (w_hold_last) begin
            r_hold_cnt <= '0;
            if (pingando) begin
              r_state <= LOCK;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        LOCK: begin
          // Every LOCK cycle with a refused eligible request is counted,
          // including the cycle in which pingando drops.
          if (w_any_elig && (blk_cnt != {NBITS_BLK{1'b1}})) begin
            blk_cnt <= blk_cnt + 1'b1;
          end
          if (!pingando) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ac_cmd_arbiter
//
// Directed testbench for ac_cmd_arbiter with default parameters
// (NREQ=3, NBITS_TEMP=3, HOLD_CYCLES=2, NBITS_BLK=4). Inputs are driven
// 1 time unit after the rising edge; outputs are sampled at the same point,
// so each sample shows the registered result of the preceding edge.
// Expected grant tables follow AC_ARB_MASTER_EN when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ac_cmd_arbiter;

  logic       clk_2;
  logic       reset;
  logic [2:0] req_up;
  logic [2:0] req_dn;
  logic       pingando;
  logic [2:0] temp_desejada;
  logic       aumentar;
  logic       diminuir;
  logic [2:0] grant;
  logic       busy;
  logic [3:0] blk_cnt;

  int errors;
  int checks;

  ac_cmd_arbiter #(
    .NREQ        (3),
    .NBITS_TEMP  (3),
    .HOLD_CYCLES (2),
    .NBITS_BLK   (4)
  ) dut (
    .clk_2         (clk_2),
    .reset         (reset),
    .req_up        (req_up),
    .req_dn        (req_dn),
    .pingando      (pingando),
    .temp_desejada (temp_desejada),
    .aumentar      (aumentar),
    .diminuir      (diminuir),
    .grant         (grant),
    .busy          (busy),
    .blk_cnt       (blk_cnt)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  // Stimulus helper: two reset edges, then all requests removed.
  task automatic do_reset();
    reset         = 1'b1;
    req_up        = 3'b000;
    req_dn        = 3'b000;
    pingando      = 1'b0;
    temp_desejada = 3'd3;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset         = 1'b1;
    req_up        = 3'b111;
    req_dn        = 3'b000;
    pingando      = 1'b0;
    temp_desejada = 3'd3;
    tick();
    tick();
    checks++;
    if (aumentar !== 1'b0) begin
      errors++;
      $display("FAIL reset_aumentar: got %b want 0", aumentar);
    end
    checks++;
    if (diminuir !== 1'b0) begin
      errors++;
      $display("FAIL reset_diminuir: got %b want 0", diminuir);
    end
    checks++;
    if (grant !== 3'b000) begin
      errors++;
      $display("FAIL reset_grant: got %b want 000", grant);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (blk_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt);
    end
    $display("reset: aumentar=%b diminuir=%b grant=%b busy=%b blk_cnt=%0d",
             aumentar, diminuir, grant, busy, blk_cnt);
    reset = 1'b0;
    req_up = 3'b000;
  endtask

  // -------------------------------------------------------------------------
  // req_up=111, temp=3: pulses 1 cycle after the request, then every 4.
  task automatic test_round_robin();
    logic [2:0] exp_g [4];
`ifdef AC_ARB_MASTER_EN
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    do_reset();
    req_up        = 3'b111;
    temp_desejada = 3'd3;
    for (int p = 0; p < 4; p++) begin
      int gap;
      gap = (p == 0) ? 1 : 4;
      for (int c = 1; c <= gap; c++) begin
        tick();
        if (c < gap) begin
          checks++;
          if ({aumentar, diminuir, grant} !== 5'b0) begin
            errors++;
            $display("FAIL rr_gap%0d_c%0d: got aum=%b dim=%b grant=%b want all 0",
                     p, c, aumentar, diminuir, grant);
          end
        end
      end
      checks++;
      if ({aumentar, diminuir, grant} !== {2'b10, exp_g[p]}) begin
        errors++;
        $display("FAIL rr_pulse%0d: got aum=%b dim=%b grant=%b want aum=1 dim=0 grant=%b",
                 p, aumentar, diminuir, grant, exp_g[p]);
      end
      $display("rr pulse %0d: aumentar=%b grant=%b busy=%b", p, aumentar, grant, busy);
    end
    // First HOLD cycle: still busy, outputs quiet.
    tick();
    checks++;
    if ({busy, aumentar, grant} !== 5'b10000) begin
      errors++;
      $display("FAIL rr_hold: got busy=%b aum=%b grant=%b want busy=1 aum=0 grant=000",
               busy, aumentar, grant);
    end
    req_up = 3'b000;
  endtask

  // -------------------------------------------------------------------------
  // Lower request from requester 2 gives a diminuir pulse.
  task automatic test_lower();
    do_reset();
    req_dn        = 3'b100;
    temp_desejada = 3'd5;
    tick();
    checks++;
    if ({aumentar, diminuir, grant} !== 5'b01100) begin
      errors++;
      $display("FAIL lower_pulse: got aum=%b dim=%b grant=%b want aum=0 dim=1 grant=100",
               aumentar, diminuir, grant);
    end
    $display("lower: diminuir=%b grant=%b", diminuir, grant);
    req_dn = 3'b000;
  endtask

  // -------------------------------------------------------------------------
  // Requests at the setpoint limits are neither granted nor counted.
  task automatic test_temp_limits();
    int pulses;
    do_reset();
    req_dn        = 3'b010;
    temp_desejada = 3'd0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (aumentar || diminuir || (grant != 3'b000)) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL min_limit_pulses: got %0d want 0", pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL min_limit_busy: got %b want 0", busy);
    end
    checks++;
    if (blk_cnt !== 4'd0) begin
      errors++;
      $display("FAIL min_limit_blk: got %0d want 0", blk_cnt);
    end
    $display("temp min: pulses=%0d busy=%b blk_cnt=%0d", pulses, busy, blk_cnt);

    // Raise at the top of the range.
    req_dn        = 3'b000;
    req_up        = 3'b001;
    temp_desejada = 3'd7;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (aumentar || diminuir || (grant != 3'b000)) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL max_limit_pulses: got %0d want 0", pulses);
    end
    $display("temp max: pulses=%0d busy=%b", pulses, busy);

    // Limit-blocked request during lockout must not be counted.
    req_up        = 3'b000;
    req_dn        = 3'b010;
    temp_desejada = 3'd0;
    pingando      = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if ({busy, blk_cnt} !== 5'b10000) begin
      errors++;
      $display("FAIL lock_limit_blk: got busy=%b blk_cnt=%0d want busy=1 blk_cnt=0",
               busy, blk_cnt);
    end
    $display("lock at limit: busy=%b blk_cnt=%0d", busy, blk_cnt);
    pingando = 1'b0;
    req_dn   = 3'b000;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Both directions asserted by one requester: ignored.
  task automatic test_invalid();
    int pulses;
    do_reset();
    req_up = 3'b100;
    req_dn = 3'b100;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (grant != 3'b000) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL invalid_grants: got %0d want 0", pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL invalid_busy: got %b want 0", busy);
    end
    $display("invalid: grants=%0d busy=%b", pulses, busy);
    req_up = 3'b000;
    req_dn = 3'b000;
  endtask

  // -------------------------------------------------------------------------
  // 20 cycles of pingando with req_up[0]: LOCK, blk_cnt saturates at 15,
  // then a pulse 2 cycles after pingando falls.
  task automatic test_lockout();
    do_reset();
    req_up        = 3'b001;
    temp_desejada = 3'd3;
    pingando      = 1'b1;
    tick();  // edge 1: IDLE -> LOCK, not yet counted
    checks++;
    if ({busy, aumentar, grant, blk_cnt} !== {1'b1, 1'b0, 3'b000, 4'd0}) begin
      errors++;
      $display("FAIL lock_enter: got busy=%b aum=%b grant=%b blk=%0d want 1 0 000 0",
               busy, aumentar, grant, blk_cnt);
    end
    for (int c = 2; c <= 5; c++) tick();
    checks++;
    if (blk_cnt !== 4'd4) begin
      errors++;
      $display("FAIL lock_count5: got %0d want 4", blk_cnt);
    end
    for (int c = 6; c <= 20; c++) tick();
    checks++;
    if ({busy, blk_cnt} !== {1'b1, 4'd15}) begin
      errors++;
      $display("FAIL lock_saturate: got busy=%b blk=%0d want busy=1 blk=15",
               busy, blk_cnt);
    end
    $display("lockout: busy=%b blk_cnt=%0d", busy, blk_cnt);
    pingando = 1'b0;
    tick();  // LOCK -> IDLE
    checks++;
    if ({busy, aumentar, blk_cnt} !== {1'b0, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL lock_exit: got busy=%b aum=%b blk=%0d want 0 0 15",
               busy, aumentar, blk_cnt);
    end
    tick();  // IDLE -> ISSUE
    checks++;
    if ({aumentar, diminuir, grant} !== 5'b10001) begin
      errors++;
      $display("FAIL lock_release_pulse: got aum=%b dim=%b grant=%b want 1 0 001",
               aumentar, diminuir, grant);
    end
    $display("lock release: aumentar=%b grant=%b", aumentar, grant);
    req_up = 3'b000;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (blk_cnt !== 4'd0) begin
      errors++;
      $display("FAIL lock_reset_blk: got %0d want 0", blk_cnt);
    end
  endtask

  // -------------------------------------------------------------------------
  // pingando rising during ISSUE does not abort: HOLD completes, then LOCK.
  task automatic test_ping_during_issue();
    do_reset();
    req_up        = 3'b010;
    temp_desejada = 3'd3;
    tick();  // ISSUE
    checks++;
    if ({aumentar, grant} !== 4'b1010) begin
      errors++;
      $display("FAIL pi_pulse: got aum=%b grant=%b want 1 010", aumentar, grant);
    end
    pingando = 1'b1;
    tick();  // HOLD 1
    tick();  // HOLD 2
    tick();  // -> LOCK
    checks++;
    if ({busy, aumentar, grant} !== 5'b10000) begin
      errors++;
      $display("FAIL pi_lock: got busy=%b aum=%b grant=%b want 1 0 000",
               busy, aumentar, grant);
    end
    pingando = 1'b0;
    tick();  // LOCK -> IDLE
    tick();  // IDLE -> ISSUE
    checks++;
    if ({aumentar, grant} !== 4'b1010) begin
      errors++;
      $display("FAIL pi_after: got aum=%b grant=%b want 1 010", aumentar, grant);
    end
    $display("ping during issue: aumentar=%b grant=%b", aumentar, grant);
    req_up = 3'b000;
  endtask

  // -------------------------------------------------------------------------
  // Reset on an ISSUE cycle: outputs clear next cycle, pointer back to 0.
  task automatic test_reset_mid_issue();
    do_reset();
    req_up        = 3'b001;
    temp_desejada = 3'd3;
    tick();  // ISSUE, winner 0
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL rm_first: got grant=%b want 001", grant);
    end
    req_up = 3'b110;
    tick();
    tick();
    tick();
    tick();  // ISSUE, winner 1
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL rm_second: got grant=%b want 010", grant);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({grant, aumentar, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL rm_cleared: got grant=%b aum=%b busy=%b want 000 0 0",
               grant, aumentar, busy);
    end
    reset  = 1'b0;
    req_up = 3'b111;
    tick();
    checks++;
    if ({aumentar, grant} !== 4'b1001) begin
      errors++;
      $display("FAIL rm_next_winner: got aum=%b grant=%b want 1 001", aumentar, grant);
    end
    $display("reset mid issue: next grant=%b", grant);
    req_up = 3'b000;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    req_up        = 3'b000;
    req_dn        = 3'b000;
    pingando      = 1'b0;
    temp_desejada = 3'd3;

    test_reset();
    test_round_robin();
    test_lower();
    test_temp_limits();
    test_invalid();
    test_lockout();
    test_ping_during_issue();
    test_reset_mid_issue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
